// File: rtl/sm4_pkg.sv
// Shared SM4 definitions: system constants, FSM states and the linear/rotation helpers.
//   FK       : key-schedule whitening constant, FK0 in [127:96]
//   SBOX     : 8-bit substitution table, entry 0 is the most significant byte
//   rotl32   : 32-bit rotate left
//   l_data   : round-function linear transform L
//   l_key    : key-schedule linear transform L'
//   ck_word  : round constant CK(i), generated arithmetically from the round index
package sm4_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BLK_W  = 128;
    localparam int unsigned NR     = 32;
    localparam int unsigned CNT_W  = 5;

    localparam logic [BLK_W-1:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

    typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} state_e;

    localparam logic [0:255][7:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    // Shifting the doubled word right by (32-n) leaves the left rotation in the low half.
    function automatic logic [WORD_W-1:0] rotl32(input logic [WORD_W-1:0] x,
                                                 input logic [CNT_W-1:0]  n);
        return WORD_W'({x, x} >> (6'd32 - {1'b0, n}));
    endfunction

    function automatic logic [WORD_W-1:0] l_data(input logic [WORD_W-1:0] b);
        return b ^ rotl32(b, 5'd2) ^ rotl32(b, 5'd10) ^ rotl32(b, 5'd18) ^ rotl32(b, 5'd24);
    endfunction

    function automatic logic [WORD_W-1:0] l_key(input logic [WORD_W-1:0] b);
        return b ^ rotl32(b, 5'd13) ^ rotl32(b, 5'd23);
    endfunction

    // Byte j of CK(i) is (4i+j)*7 mod 256; the 8-bit product wraps for free.
    function automatic logic [WORD_W-1:0] ck_word(input logic [CNT_W-1:0] i);
        logic [WORD_W-1:0] ck;
        ck = '0;
        for (int j = 0; j < 4; j++) begin
            ck[31-8*j -: 8] = 8'({1'b0, i, 2'(j)} * 8'd7);
        end
        return ck;
    endfunction

endpackage

// File: rtl/sm4_tau.sv
// Non-linear stage tau: four parallel S-boxes on a 32-bit word, purely combinational.
//   a : input word
//   b : substituted word, byte-for-byte
module sm4_tau
    import sm4_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    output logic [WORD_W-1:0] b
);

    assign b = {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};

endmodule

// File: rtl/sm4_dec_iter.sv
// Iterative SM4 core, one round per clock, decrypt by default (encrypt when ENC_SUPPORT=1 and enc=1).
//   clk, rst             : clock, synchronous active-high reset
//   key_load, key_in     : start key expansion (accepted in IDLE only)
//   key_ready            : round-key array valid
//   in_valid/in_ready    : input handshake for din (+ enc)
//   out_valid/out_ready  : output handshake for dout, dout held until consumed
//   busy                 : FSM not in IDLE
module sm4_dec_iter #(
    parameter bit ENC_SUPPORT = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_load,
    input  logic [127:0] key_in,
    output logic         key_ready,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] din,
    input  logic         enc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] dout,
    output logic         busy
);
    import sm4_pkg::*;

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic [BLK_W-1:0]   k_q;
    logic [BLK_W-1:0]   x_q;
    logic [WORD_W-1:0]  rk_q [NR];
    logic               enc_q;

    logic [CNT_W-1:0]   rk_idx;
    logic [WORD_W-1:0]  key_tau_in;
    logic [WORD_W-1:0]  key_tau_out;
    logic [WORD_W-1:0]  data_tau_in;
    logic [WORD_W-1:0]  data_tau_out;
    logic [WORD_W-1:0]  rk_new;
    logic [WORD_W-1:0]  x_new;

    // Decrypt walks the keys backwards; ~cnt equals 31-cnt for a 5-bit counter.
    assign rk_idx = (ENC_SUPPORT && enc_q) ? cnt : ~cnt;

    // Separate S-box stages for key schedule and data rounds.
    assign key_tau_in  = k_q[95:64] ^ k_q[63:32] ^ k_q[31:0] ^ ck_word(cnt);
    assign data_tau_in = x_q[95:64] ^ x_q[63:32] ^ x_q[31:0] ^ rk_q[rk_idx];

    sm4_tau u_tau_key  (.a(key_tau_in),  .b(key_tau_out));
    sm4_tau u_tau_data (.a(data_tau_in), .b(data_tau_out));

    assign rk_new = k_q[127:96] ^ l_key(key_tau_out);
    assign x_new  = x_q[127:96] ^ l_data(data_tau_out);

    // key_load wins over a data handshake in the same cycle.
    assign in_ready = (state == IDLE) && key_ready && !key_load;
    assign busy     = (state != IDLE);

    // Control FSM plus key/data shift registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            key_ready <= 1'b0;
            out_valid <= 1'b0;
            dout      <= '0;
            enc_q     <= 1'b0;
            k_q       <= '0;
            x_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_load) begin
                        k_q       <= key_in ^ FK;
                        key_ready <= 1'b0;
                        cnt       <= '0;
                        state     <= KEYEXP;
                    end else if (in_valid && in_ready) begin
                        x_q   <= din;
                        enc_q <= enc;
                        cnt   <= '0;
                        state <= ROUND;
                    end
                end
                KEYEXP: begin
                    rk_q[cnt] <= rk_new;
                    k_q       <= {k_q[95:0], rk_new};
                    cnt       <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        key_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                ROUND: begin
                    x_q <= {x_q[95:0], x_new};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        dout      <= {x_new, x_q[31:0], x_q[63:32], x_q[95:64]};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sm4_dec_iter.sv
// Self-checking bench for sm4_dec_iter: known-answer vectors, random vectors against a
// behavioural SM4 model, and hand sequences for handshake, gating and reset corners.
module tb_sm4_dec_iter;

    localparam logic [127:0] KAT_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] KAT_PT  = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] KAT_CT  = 128'h681EDF34D206965E86B3E94F536E4246;

    localparam logic [0:255][7:0] SB = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };
    localparam logic [31:0] FK_TB [4] = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_load = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_ready;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] din = '0;
    logic         enc = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] dout;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sm4_dec_iter #(.ENC_SUPPORT(1'b1)) dut (
        .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in), .key_ready(key_ready),
        .in_valid(in_valid), .in_ready(in_ready), .din(din), .enc(enc),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .busy(busy)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] rot(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] sub(input logic [31:0] x);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[31-8*j -: 8] = SB[x[31-8*j -: 8]];
        return r;
    endfunction

    function automatic logic [31:0] ref_rk(input logic [127:0] key, input int idx);
        logic [31:0] k [36];
        logic [31:0] ck;
        for (int i = 0; i < 4; i++) k[i] = key[127-32*i -: 32] ^ FK_TB[i];
        for (int i = 0; i < 32; i++) begin
            ck = '0;
            for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(((4 * i + j) * 7) % 256);
            k[i+4] = sub(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
            k[i+4] = k[i] ^ k[i+4] ^ rot(k[i+4], 13) ^ rot(k[i+4], 23);
        end
        return k[idx+4];
    endfunction

    function automatic logic [127:0] ref_sm4(input logic [127:0] key, input logic [127:0] blk,
                                             input bit e);
        logic [31:0] x [36];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) x[i] = blk[127-32*i -: 32];
        for (int i = 0; i < 32; i++) begin
            t = sub(x[i+1] ^ x[i+2] ^ x[i+3] ^ ref_rk(key, e ? i : 31 - i));
            x[i+4] = x[i] ^ t ^ rot(t, 2) ^ rot(t, 10) ^ rot(t, 18) ^ rot(t, 24);
        end
        return {x[35], x[34], x[33], x[32]};
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [127:0] k, output int lat);
        key_in   = k;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        lat = 0;
        while (!key_ready && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    // Returns result and cycles from the handshake cycle (0) to out_valid.
    task automatic run_block(input logic [127:0] d, input bit e,
                             output logic [127:0] res, output int lat);
        int w;
        din = d;
        enc = e;
        in_valid = 1'b1;
        #1;
        w = 0;
        while (!in_ready && w < 100) begin
            tick();
            w++;
        end
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        res = dout;
    endtask

    task automatic ack();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [127:0] key;
        logic [127:0] din;
        bit           enc;
        logic [127:0] exp;
    } vec_t;

    vec_t         vecs [8];
    logic [127:0] res, held, prev_key, rkey;
    int           lat;
    bit           saw_out;

    initial begin
        // ---------------- vector table ----------------
        vecs[0] = '{KAT_KEY, KAT_CT, 1'b0, KAT_PT};
        vecs[1] = '{KAT_KEY, KAT_PT, 1'b1, KAT_CT};
        for (int i = 2; i < 8; i++) begin
            vecs[i].key = (i == 4) ? vecs[3].key : {$urandom, $urandom, $urandom, $urandom};
            vecs[i].din = {$urandom, $urandom, $urandom, $urandom};
            vecs[i].enc = 1'($urandom_range(0, 1));
            vecs[i].exp = ref_sm4(vecs[i].key, vecs[i].din, vecs[i].enc);
        end

        // ---------------- reset state ----------------
        tick();
        tick();
        rst = 1'b0;
        chk_int("rst_key_ready", int'(key_ready), 0);
        chk_int("rst_out_valid", int'(out_valid), 0);
        chk("rst_dout", dout, '0);
        chk_int("rst_busy", int'(busy), 0);

        // ---------------- no key: data refused ----------------
        in_valid = 1'b1;
        din = KAT_CT;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk_int("nokey_in_ready", int'(in_ready), 0);
            tick();
            chk_int("nokey_busy", int'(busy), 0);
        end
        in_valid = 1'b0;

        // ---------------- key expansion ----------------
        load_key(KAT_KEY, lat);
        chk_int("keyexp_latency", lat, 32);
        chk("rk0", 128'(dut.rk_q[0]), 128'(32'hF12186F9));
        chk("rk31", 128'(dut.rk_q[31]), 128'(32'h9124A012));
        prev_key = KAT_KEY;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].key !== prev_key) begin
                load_key(vecs[i].key, lat);
                chk_int("vec_keyexp_latency", lat, 32);
                prev_key = vecs[i].key;
            end
            run_block(vecs[i].din, vecs[i].enc, res, lat);
            chk($sformatf("vec%0d_dout", i), res, vecs[i].exp);
            chk_int($sformatf("vec%0d_latency", i), lat, 33);
            ack();
        end

        // ---------------- key_load and in_valid together ----------------
        in_valid = 1'b1;
        din      = KAT_CT;
        enc      = 1'b0;
        key_in   = KAT_KEY;
        key_load = 1'b1;
        #1;
        chk_int("collide_in_ready", int'(in_ready), 0);
        tick();
        in_valid = 1'b0;
        key_load = 1'b0;
        chk_int("collide_busy", int'(busy), 1);
        chk_int("collide_key_ready", int'(key_ready), 0);
        saw_out = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid) saw_out = 1'b1;
            tick();
        end
        chk_int("collide_key_ready_after", int'(key_ready), 1);
        chk_int("collide_no_output", int'(saw_out), 0);
        chk_int("collide_idle", int'(busy), 0);

        // ---------------- key_load ignored in ROUND, then backpressure ----------------
        din = KAT_CT;
        enc = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        key_in   = {$urandom, $urandom, $urandom, $urandom};
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        held = dout;
        chk("bp_dout", held, KAT_PT);
        din = KAT_PT;
        enc = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("bp_dout_stable", dout, held);
            chk_int("bp_out_valid", int'(out_valid), 1);
            chk_int("bp_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        #1;
        chk_int("bp_in_ready_at_ack", int'(in_ready), 0);
        tick();
        out_ready = 1'b0;
        chk_int("bp_out_valid_cleared", int'(out_valid), 0);
        chk_int("bp_in_ready_after_ack", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk_int("bp_next_accepted", int'(busy), 1);
        lat = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk_int("bp_next_latency", lat, 33);
        chk("bp_next_dout_old_key", dout, KAT_CT);
        ack();

        // ---------------- reset mid-ROUND ----------------
        din = KAT_CT;
        enc = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 14; c++) tick();
        chk_int("mid_round_busy", int'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_int("midrst_busy", int'(busy), 0);
        chk_int("midrst_out_valid", int'(out_valid), 0);
        chk_int("midrst_key_ready", int'(key_ready), 0);
        in_valid = 1'b1;
        #1;
        chk_int("midrst_in_ready", int'(in_ready), 0);
        in_valid = 1'b0;
        rkey = {$urandom, $urandom, $urandom, $urandom};
        load_key(rkey, lat);
        chk_int("rekey_latency", lat, 32);
        held = {$urandom, $urandom, $urandom, $urandom};
        run_block(held, 1'b0, res, lat);
        chk("rekey_dout", res, ref_sm4(rkey, held, 1'b0));
        chk_int("rekey_latency_data", lat, 33);
        ack();
        load_key(KAT_KEY, lat);
        run_block(KAT_CT, 1'b0, res, lat);
        chk("rekey_kat_dout", res, KAT_PT);
        ack();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
